// File: rtl/tia_color_lum_writer.sv
// tia_color_lum_writer
// Buffers colour/luminance register writes in a small FIFO and replays each
// one onto the TIA register file as a SETUP / STROBE / HOLD sequence. The d
// lines stay stable around the strobe. A shadow copy of every register is
// kept for readback.
module tia_color_lum_writer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clkp,
  input  logic                          reset,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [1:0]                    wr_sel,
  input  logic [6:0]                    wr_data,
  output logic                          d1,
  output logic                          d2,
  output logic                          d3,
  output logic                          d4,
  output logic                          d5,
  output logic                          d6,
  output logic                          d7,
  output logic                          bkci,
  output logic                          pfci,
  output logic                          p1ci,
  output logic                          p0ci,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic [6:0]                    shadow_bk,
  output logic [6:0]                    shadow_pf,
  output logic [6:0]                    shadow_p1,
  output logic [6:0]                    shadow_p0
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t        state;
  state_t        next_state;

  // Each FIFO entry carries the target select above the 7-bit data.
  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic [6:0]    cur_data;
  logic [1:0]    cur_sel;

  logic          push;
  logic          pop;
  logic          fifo_empty;

  // Ready depends only on registered occupancy, so a full FIFO never pushes.
  assign fifo_empty = (level == '0);
  assign wr_ready   = (level != FULL_LEVEL);
  assign push       = wr_valid && wr_ready;
  assign busy       = (state != S_IDLE) || !fifo_empty;

  assign d1 = cur_data[0];
  assign d2 = cur_data[1];
  assign d3 = cur_data[2];
  assign d4 = cur_data[3];
  assign d5 = cur_data[4];
  assign d6 = cur_data[5];
  assign d7 = cur_data[6];

  // FSM state register.
  always_ff @(posedge clkp) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next state, pop decision and one-hot strobe decode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and infers a latch.
    next_state = state;
    pop        = 1'b0;
    bkci       = 1'b0;
    pfci       = 1'b0;
    p1ci       = 1'b0;
    p0ci       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          next_state = S_SETUP;
        end
      end
      S_SETUP: begin
        next_state = S_STROBE;
      end
      S_STROBE: begin
        bkci       = (cur_sel == 2'd0);
        pfci       = (cur_sel == 2'd1);
        p1ci       = (cur_sel == 2'd2);
        p0ci       = (cur_sel == 2'd3);
        next_state = S_HOLD;
      end
      S_HOLD: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          next_state = S_SETUP;
        end else begin
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // FIFO pointers and occupancy; level alone tells full from empty.
  always_ff @(posedge clkp) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clkp) begin
    // NOTE: the storage array is deliberately not reset; entries are only
    // read after being written, and the pointers/level carry the valid state.
    if (push) mem[wr_ptr] <= {wr_sel, wr_data};
  end

  // Popped write drives the d lines; shadows capture at the end of STROBE.
  always_ff @(posedge clkp) begin
    if (reset) begin
      cur_data  <= '0;
      cur_sel   <= '0;
      shadow_bk <= '0;
      shadow_pf <= '0;
      shadow_p1 <= '0;
      shadow_p0 <= '0;
    end else begin
      if (pop) begin
        cur_sel  <= mem[rd_ptr][8:7];
        cur_data <= mem[rd_ptr][6:0];
      end
      if (state == S_STROBE) begin
        unique case (cur_sel)
          2'd0:    shadow_bk <= cur_data;
          2'd1:    shadow_pf <= cur_data;
          2'd2:    shadow_p1 <= cur_data;
          default: shadow_p0 <= cur_data;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tia_color_lum_writer.sv
// Directed bench for tia_color_lum_writer: reset values, single-write timing,
// back-to-back spacing, full-FIFO back-pressure, reset during STROBE and a
// randomised one-hot / ordering run against a last-write-per-register model.
module tb_tia_color_lum_writer;

  logic       clkp = 1'b0;
  logic       reset;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_sel;
  logic [6:0] wr_data;
  logic       d1, d2, d3, d4, d5, d6, d7;
  logic       bkci, pfci, p1ci, p0ci;
  logic       busy;
  logic [2:0] level;
  logic [6:0] shadow_bk, shadow_pf, shadow_p1, shadow_p0;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [1:0] sel;
    logic [6:0] data;
    int         cyc;
  } ev_t;

  ev_t log_q[$];
  ev_t exp_q[$];

  logic [6:0] dv;
  assign dv = {d7, d6, d5, d4, d3, d2, d1};

  tia_color_lum_writer #(.FIFO_DEPTH(4)) dut (
    .clkp(clkp), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_sel(wr_sel), .wr_data(wr_data),
    .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7),
    .bkci(bkci), .pfci(pfci), .p1ci(p1ci), .p0ci(p0ci),
    .busy(busy), .level(level),
    .shadow_bk(shadow_bk), .shadow_pf(shadow_pf),
    .shadow_p1(shadow_p1), .shadow_p0(shadow_p0)
  );

  always #5 clkp = ~clkp;
  always @(posedge clkp) cyc++;

  // Strobe monitor: one-hot, single-cycle pulses, d stable around each pulse.
  logic       prev_valid  = 1'b0;
  logic       prev_strobe = 1'b0;
  logic [6:0] prev_d      = '0;
  int         n_strobe;
  ev_t        ev;

  always @(negedge clkp) begin
    if (reset) begin
      prev_valid  = 1'b0;
      prev_strobe = 1'b0;
    end else begin
      n_strobe = $countones({bkci, pfci, p1ci, p0ci});
      checks++;
      if (n_strobe > 1) begin
        errors++;
        $display("FAIL onehot: strobes=%b required at most one high", {bkci, pfci, p1ci, p0ci});
      end
      if (n_strobe == 1) begin
        ev.sel  = bkci ? 2'd0 : pfci ? 2'd1 : p1ci ? 2'd2 : 2'd3;
        ev.data = dv;
        ev.cyc  = cyc;
        log_q.push_back(ev);
        checks++;
        if (!prev_valid || prev_strobe || prev_d !== dv) begin
          errors++;
          $display("FAIL strobe_setup: d before=%b d at strobe=%b prev_strobe=%b required stable d and no strobe before",
                   prev_d, dv, prev_strobe);
        end
      end
      if (prev_strobe) begin
        checks++;
        if (n_strobe != 0 || dv !== prev_d) begin
          errors++;
          $display("FAIL strobe_hold: d after=%b strobes=%0d required d=%b and no strobe", dv, n_strobe, prev_d);
        end
      end
      prev_strobe = (n_strobe != 0);
      prev_d      = dv;
      prev_valid  = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clkp);
    #1;
  endtask

  // Offer one write and hold it until accepted; wr_valid is left high.
  task automatic send(input logic [1:0] sel, input logic [6:0] data);
    int  n;
    ev_t e;
    wr_valid = 1'b1;
    wr_sel   = sel;
    wr_data  = data;
    n = 0;
    while (!wr_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: wr_ready stayed %b required 1 within 50 cycles", wr_ready);
    end
    e.sel  = sel;
    e.data = data;
    e.cyc  = 0;
    exp_q.push_back(e);
    tick();
  endtask

  task automatic drain();
    int n;
    wr_valid = 1'b0;
    n = 0;
    while (busy && n < 2000) begin
      tick();
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL drain_timeout: busy=%b required 0 within 2000 cycles", busy);
    end
    tick();
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    wr_valid = 1'b1;
    wr_sel   = 2'd1;
    wr_data  = 7'h55;
    tick();
    tick();
    checks++;
    if (level !== 3'd0) begin
      errors++;
      $display("FAIL reset_ignore_valid: level=%0d required 0", level);
    end
    reset    = 1'b0;
    wr_valid = 1'b0;
    log_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (wr_ready !== 1'b1 || busy !== 1'b0 || level !== 3'd0) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%b busy=%b level=%0d required 1 0 0", wr_ready, busy, level);
    end
    checks++;
    if (dv !== 7'd0 || {bkci, pfci, p1ci, p0ci} !== 4'd0) begin
      errors++;
      $display("FAIL reset_lines: d=%b strobes=%b required 0 0", dv, {bkci, pfci, p1ci, p0ci});
    end
    checks++;
    if ({shadow_bk, shadow_pf, shadow_p1, shadow_p0} !== 28'd0) begin
      errors++;
      $display("FAIL reset_shadows: %h %h %h %h required all 0", shadow_bk, shadow_pf, shadow_p1, shadow_p0);
    end
  endtask

  task automatic test_single_write();
    wr_valid = 1'b1;
    wr_sel   = 2'd0;
    wr_data  = 7'b0000111;
    tick();                       // edge k: push
    wr_valid = 1'b0;
    checks++;
    if (level !== 3'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_push: level=%0d busy=%b required 1 1", level, busy);
    end
    tick();                       // k+1: SETUP
    checks++;
    if (dv !== 7'b0000111 || {bkci, pfci, p1ci, p0ci} !== 4'b0000) begin
      errors++;
      $display("FAIL single_setup: d=%b strobes=%b required 0000111 0000", dv, {bkci, pfci, p1ci, p0ci});
    end
    tick();                       // k+2: STROBE
    checks++;
    if ({bkci, pfci, p1ci, p0ci} !== 4'b1000 || dv !== 7'b0000111) begin
      errors++;
      $display("FAIL single_strobe: strobes=%b d=%b required 1000 0000111", {bkci, pfci, p1ci, p0ci}, dv);
    end
    tick();                       // k+3: HOLD
    checks++;
    if ({bkci, pfci, p1ci, p0ci} !== 4'b0000 || dv !== 7'b0000111 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_hold: strobes=%b d=%b busy=%b required 0000 0000111 1",
               {bkci, pfci, p1ci, p0ci}, dv, busy);
    end
    checks++;
    if (shadow_bk !== 7'b0000111 || {shadow_pf, shadow_p1, shadow_p0} !== 21'd0) begin
      errors++;
      $display("FAIL single_shadow: bk=%b pf=%b p1=%b p0=%b required 0000111 0 0 0",
               shadow_bk, shadow_pf, shadow_p1, shadow_p0);
    end
    tick();                       // k+4: IDLE
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single_busy_fall: busy=%b required 0", busy);
    end
    log_q.delete();
  endtask

  task automatic test_back_to_back();
    log_q.delete();
    exp_q.delete();
    send(2'd0, 7'b0001110);
    send(2'd1, 7'b1111111);
    send(2'd2, 7'b0101010);
    send(2'd3, 7'b1010101);
    drain();
    checks++;
    if (log_q.size() != 4) begin
      errors++;
      $display("FAIL b2b_count: strobes=%0d required 4", log_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (log_q[i].sel !== exp_q[i].sel || log_q[i].data !== exp_q[i].data) begin
          errors++;
          $display("FAIL b2b_order[%0d]: sel=%0d data=%b required sel=%0d data=%b",
                   i, log_q[i].sel, log_q[i].data, exp_q[i].sel, exp_q[i].data);
        end
        if (i > 0) begin
          checks++;
          if (log_q[i].cyc - log_q[i-1].cyc != 3) begin
            errors++;
            $display("FAIL b2b_spacing[%0d]: gap=%0d cycles required 3", i, log_q[i].cyc - log_q[i-1].cyc);
          end
        end
      end
    end
    checks++;
    if (shadow_bk !== 7'b0001110 || shadow_pf !== 7'b1111111 ||
        shadow_p1 !== 7'b0101010 || shadow_p0 !== 7'b1010101) begin
      errors++;
      $display("FAIL b2b_shadows: bk=%b pf=%b p1=%b p0=%b required 0001110 1111111 0101010 1010101",
               shadow_bk, shadow_pf, shadow_p1, shadow_p0);
    end
  endtask

  // Continuous wr_valid from empty; levels and ready hand-traced per edge.
  task automatic test_full_fifo();
    logic [2:0] lvl_tab [10] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4, 3'd3, 3'd4, 3'd4};
    logic       rdy_tab [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int   i;
    int   e;
    logic acc;
    ev_t  x;
    log_q.delete();
    exp_q.delete();
    i = 0;
    e = 0;
    while (i < 8 && e < 60) begin
      wr_valid = 1'b1;
      wr_sel   = 2'(i);
      wr_data  = 7'(8'h11 * (i + 1));
      acc      = wr_ready;
      tick();
      if (acc) begin
        x.sel  = wr_sel;
        x.data = wr_data;
        x.cyc  = 0;
        exp_q.push_back(x);
        i++;
      end
      if (e < 10) begin
        checks++;
        if (level !== lvl_tab[e] || wr_ready !== rdy_tab[e]) begin
          errors++;
          $display("FAIL full_level[%0d]: level=%0d ready=%b required %0d %b",
                   e, level, wr_ready, lvl_tab[e], rdy_tab[e]);
        end
      end
      e++;
    end
    drain();
    checks++;
    if (log_q.size() != 8) begin
      errors++;
      $display("FAIL full_count: strobes=%0d required 8", log_q.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (log_q[k].sel !== exp_q[k].sel || log_q[k].data !== exp_q[k].data) begin
          errors++;
          $display("FAIL full_order[%0d]: sel=%0d data=%b required sel=%0d data=%b",
                   k, log_q[k].sel, log_q[k].data, exp_q[k].sel, exp_q[k].data);
        end
      end
    end
  endtask

  task automatic test_reset_in_strobe();
    do_reset();
    wr_valid = 1'b1;
    wr_sel   = 2'd1;
    wr_data  = 7'b1111111;
    tick();                       // push
    wr_valid = 1'b0;
    tick();                       // SETUP
    tick();                       // STROBE
    checks++;
    if (pfci !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_strobe: pfci=%b required 1", pfci);
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({bkci, pfci, p1ci, p0ci} !== 4'd0 || dv !== 7'd0 || shadow_pf !== 7'd0 ||
        level !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_strobe_cut: strobes=%b d=%b shadow_pf=%b level=%0d busy=%b required 0 0 0 0 0",
               {bkci, pfci, p1ci, p0ci}, dv, shadow_pf, level, busy);
    end
    reset = 1'b0;
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready: wr_ready=%b required 1", wr_ready);
    end
    log_q.delete();
    send(2'd2, 7'b0011001);
    drain();
    checks++;
    if (shadow_p1 !== 7'b0011001 || shadow_pf !== 7'd0 || log_q.size() != 1) begin
      errors++;
      $display("FAIL rst_recover: shadow_p1=%b shadow_pf=%b strobes=%0d required 0011001 0 1",
               shadow_p1, shadow_pf, log_q.size());
    end
  endtask

  task automatic test_random();
    logic [6:0] model [4];
    logic [1:0] s;
    logic [6:0] dd;
    int         bad;
    do_reset();
    for (int r = 0; r < 4; r++) model[r] = '0;
    for (int w = 0; w < 200; w++) begin
      wr_valid = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
      s  = 2'($urandom_range(0, 3));
      dd = 7'($urandom);
      model[s] = dd;
      send(s, dd);
    end
    drain();
    checks++;
    if (log_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rand_count: strobes=%0d required %0d", log_q.size(), exp_q.size());
    end else begin
      bad = 0;
      for (int k = 0; k < exp_q.size(); k++)
        if (log_q[k].sel !== exp_q[k].sel || log_q[k].data !== exp_q[k].data) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL rand_order: %0d entries out of order or wrong, required 0", bad);
      end
    end
    checks++;
    if (shadow_bk !== model[0] || shadow_pf !== model[1] ||
        shadow_p1 !== model[2] || shadow_p0 !== model[3]) begin
      errors++;
      $display("FAIL rand_shadows: %b %b %b %b required %b %b %b %b",
               shadow_bk, shadow_pf, shadow_p1, shadow_p0, model[0], model[1], model[2], model[3]);
    end
  endtask

  initial begin
    reset    = 1'b1;
    wr_valid = 1'b0;
    wr_sel   = '0;
    wr_data  = '0;
    tick();
    test_reset();
    test_single_write();
    test_back_to_back();
    test_full_fifo();
    test_reset_in_strobe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
